// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared constants, state encoding and helpers for the UART
//            receive controller slice.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Controller state encoding (explicit 2-bit width)
    localparam logic [1:0] ST_OFF   = 2'd0;
    localparam logic [1:0] ST_RXRST = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

    // Legal character sizes and the smallest usable baud divisor
    localparam int CHAR_MIN = 5;
    localparam int CHAR_MAX = 8;
    localparam int DIV_MIN  = 2;

    // 100 MHz system clock / 115200 baud
    localparam int CLK_DIV_DEFAULT = 868;

    // True when a requested character size is one the receiver supports
    function automatic logic size_ok(input logic [3:0] s);
        return (s >= 4'(CHAR_MIN)) && (s <= 4'(CHAR_MAX));
    endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Brief    : Synchronous show-ahead FIFO with push, pop, flush and occupancy.
//            A push into a full FIFO is accepted only alongside a pop.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic [WIDTH-1:0]         o_rdata,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == (c_AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];
    // A full FIFO still takes a push when the head leaves in the same cycle
    assign w_do_push = i_push && (!o_full || i_pop);
    assign w_do_pop  = i_pop && !o_empty;

    // Storage write; flush discards any same-cycle push
    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers and occupancy; power-of-two depth lets the pointers wrap naturally
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
            r_count <= r_count + (c_AW+1)'(w_do_push) - (c_AW+1)'(w_do_pop);
        end
    end

endmodule : uart_rx_fifo
`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_ctrl
// Brief    : Sequences a uart_receiver: baud clock generation, receiver
//            reset/enable, character capture into a show-ahead FIFO, sticky
//            overflow and a config/pop interface.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = CLK_DIV_DEFAULT,
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_wr,
    input  logic                          cfg_en,
    input  logic                          cfg_flush,
    input  logic [DIV_W-1:0]              cfg_div,
    input  logic [3:0]                    cfg_char_size,
    output logic                          cfg_err,
    input  logic                          rd_en,
    output logic                          rd_valid,
    output logic [7:0]                    rd_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    input  logic                          ovf_clr,
    output logic                          rx_baud,
    output logic                          rx_rst,
    output logic                          rx_en,
    output logic [3:0]                    rx_char_size,
    input  logic                          rx_rdy,
    input  logic [7:0]                    rx_data
);

    logic [1:0]       r_state;
    logic             r_wraps;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_div_act;
    logic [DIV_W-1:0] r_cnt;
    logic             r_baud;
    logic [3:0]       r_char_size;
    logic             r_cfg_err;
    logic             r_rdy_q;
    logic             r_armed;
    logic             r_overflow;

    logic             w_cfg_ok;
    logic             w_flush;
    logic [DIV_W-1:0] w_div_in;
    logic             w_wrap;
    logic             w_push_evt;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic             w_ovf_evt;
    logic [7:0]       w_mask;

    assign w_cfg_ok   = cfg_wr && size_ok(cfg_char_size);
    assign w_flush    = w_cfg_ok && cfg_flush;
    assign w_div_in   = (cfg_div < DIV_W'(DIV_MIN)) ? DIV_W'(DIV_MIN) : cfg_div;
    assign w_wrap     = (r_cnt == r_div_act - DIV_W'(1));
    // Only a rising rdy that follows a low seen while running is a new character
    assign w_push_evt = (r_state == ST_RUN) && r_armed && rx_rdy && !r_rdy_q;
    assign w_pop      = rd_en && !w_empty;
    assign w_ovf_evt  = w_push_evt && w_full && !rd_en && !w_flush;

    // Keep only the bits of the current character; higher bits may be stale
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < 8; i++) begin
            w_mask[i] = (4'(i) < r_char_size);
        end
    end

    // Baud counter; the active divisor only changes at a wrap so no period is cut short
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_div_act <= DIV_W'(CLK_DIV);
            r_baud    <= 1'b0;
        end else begin
            if (w_wrap) begin
                r_cnt     <= '0;
                r_div_act <= r_div;
            end else begin
                r_cnt <= r_cnt + DIV_W'(1);
            end
            r_baud <= (r_cnt < (r_div_act >> 1));
        end
    end

    // Configuration latch and reject pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div       <= DIV_W'(CLK_DIV);
            r_char_size <= 4'd8;
            r_cfg_err   <= 1'b0;
        end else begin
            r_cfg_err <= cfg_wr && !size_ok(cfg_char_size);
            if (w_cfg_ok) begin
                r_div       <= w_div_in;
                r_char_size <= cfg_char_size;
            end
        end
    end

    // Control FSM; the receiver sees rst only on baud edges, so hold it over two wraps
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_OFF;
            r_wraps <= 1'b0;
        end else if (w_cfg_ok) begin
            r_state <= cfg_en ? ST_RXRST : ST_OFF;
            r_wraps <= 1'b0;
        end else begin
            case (r_state)
                ST_OFF: r_state <= ST_OFF;
                ST_RXRST: begin
                    if (w_wrap) begin
                        if (r_wraps) begin
                            r_state <= ST_RUN;
                            r_wraps <= 1'b0;
                        end else begin
                            r_wraps <= 1'b1;
                        end
                    end
                end
                ST_RUN:  r_state <= ST_RUN;
                default: r_state <= ST_OFF;
            endcase
        end
    end

    // rdy edge tracking and arming; arming is dropped outside RUN so no partial frame lands
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdy_q <= 1'b1;
            r_armed <= 1'b0;
        end else begin
            r_rdy_q <= rx_rdy;
            if (r_state != ST_RUN) begin
                r_armed <= 1'b0;
            end else if (!rx_rdy) begin
                r_armed <= 1'b1;
            end else if (w_push_evt) begin
                r_armed <= 1'b0;
            end
        end
    end

    // Sticky overflow; a same-cycle drop beats the clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_ovf_evt) begin
            r_overflow <= 1'b1;
        end else if (ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push_evt && !w_flush),
        .i_wdata (rx_data & w_mask),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .o_rdata (rd_data),
        .o_count (fifo_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign rd_valid     = !w_empty;
    assign overflow     = r_overflow;
    assign cfg_err      = r_cfg_err;
    assign rx_baud      = r_baud;
    assign rx_rst       = (r_state != ST_RUN);
    assign rx_en        = (r_state == ST_RUN);
    assign rx_char_size = r_char_size;

endmodule : uart_rx_ctrl
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_ctrl
// Brief    : Self-checking bench for uart_rx_ctrl. Plays the receiver's rdy/data
//            handshake and compares against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_ctrl;

    localparam int c_DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_wr, cfg_en, cfg_flush;
    logic [15:0] cfg_div;
    logic [3:0]  cfg_char_size;
    logic        cfg_err;
    logic        rd_en, rd_valid;
    logic [7:0]  rd_data;
    logic [3:0]  fifo_count;
    logic        overflow, ovf_clr;
    logic        rx_baud, rx_rst, rx_en;
    logic [3:0]  rx_char_size;
    logic        rx_rdy;
    logic [7:0]  rx_data;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [7:0] exp_q[$];
    logic       exp_ovf;
    int         exp_size;
    int         rst_len;
    int         per;

    always #5 clk = ~clk;

    uart_rx_ctrl #(.CLK_DIV(868), .FIFO_DEPTH(c_DEPTH), .DIV_W(16)) dut (
        .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_en(cfg_en), .cfg_flush(cfg_flush),
        .cfg_div(cfg_div), .cfg_char_size(cfg_char_size), .cfg_err(cfg_err),
        .rd_en(rd_en), .rd_valid(rd_valid), .rd_data(rd_data), .fifo_count(fifo_count),
        .overflow(overflow), .ovf_clr(ovf_clr), .rx_baud(rx_baud), .rx_rst(rx_rst),
        .rx_en(rx_en), .rx_char_size(rx_char_size), .rx_rdy(rx_rdy), .rx_data(rx_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_fifo(input string tag);
        chk({tag, ".count"}, 32'(fifo_count), 32'(exp_q.size()));
        chk({tag, ".valid"}, 32'(rd_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) chk({tag, ".data"}, 32'(rd_data), 32'(exp_q[0]));
        chk({tag, ".ovf"}, 32'(overflow), 32'(exp_ovf));
    endtask

    // Receiver delivers one character: rdy low while shifting, then data + rdy high
    task automatic send(input logic [7:0] d, input bit with_pop, input bit with_clr);
        logic [7:0] m;
        rx_rdy = 1'b0;
        repeat (3) tick();
        rx_data = d;
        rx_rdy  = 1'b1;
        rd_en   = with_pop;
        ovf_clr = with_clr;
        tick();
        rd_en   = 1'b0;
        ovf_clr = 1'b0;
        m = d & 8'((1 << exp_size) - 1);
        if (with_pop && exp_q.size() != 0) void'(exp_q.pop_front());
        if (with_clr) exp_ovf = 1'b0;
        if (exp_q.size() == c_DEPTH) exp_ovf = 1'b1;
        else exp_q.push_back(m);
        tick();
    endtask

    task automatic pop(input string tag);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        check_fifo(tag);
    endtask

    task automatic cfg(input bit en, input bit flush, input logic [15:0] div, input logic [3:0] size);
        bit ok;
        ok = (size >= 5) && (size <= 8);
        cfg_en = en; cfg_flush = flush; cfg_div = div; cfg_char_size = size;
        cfg_wr = 1'b1;
        tick();
        cfg_wr  = 1'b0;
        rst_len = int'(rx_rst);
        chk("cfg_err_pulse", 32'(cfg_err), 32'(!ok));
        tick();
        rst_len += int'(rx_rst);
        chk("cfg_err_clear", 32'(cfg_err), 32'(0));
        if (ok) begin
            exp_size = int'(size);
            if (flush) exp_q.delete();
        end
        chk("char_size", 32'(rx_char_size), 32'(exp_size));
    endtask

    task automatic wait_run();
        int n;
        bit done;
        n = 0;
        done = (rx_rst === 1'b0);
        while (!done && n < 4000) begin
            tick();
            n++;
            if (rx_rst === 1'b1) rst_len++;
            else done = 1'b1;
        end
        chk("run_reached", 32'(done), 32'(1));
        chk("run_rx_en", 32'(rx_en), 32'(1));
    endtask

    task automatic baud_period(output int p);
        int  n;
        bit  prev;
        bit  seen;
        p = -1;
        seen = 1'b0;
        prev = rx_baud;
        n = 0;
        while (!seen && n < 4000) begin
            tick(); n++;
            if (!prev && rx_baud) seen = 1'b1;
            prev = rx_baud;
        end
        if (seen) begin
            n = 0;
            seen = 1'b0;
            while (!seen && n < 4000) begin
                tick(); n++;
                if (!prev && rx_baud) begin
                    seen = 1'b1;
                    p = n;
                end
                prev = rx_baud;
            end
        end
    endtask

    // Hard stop if something stalls far beyond the expected run length
    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cfg_wr = 0; cfg_en = 0; cfg_flush = 0; cfg_div = 16'd16;
        cfg_char_size = 4'd8; rd_en = 0; ovf_clr = 0; rx_rdy = 1'b1; rx_data = 8'h00;
        exp_ovf = 1'b0; exp_size = 8; rst_len = 0;
        repeat (3) tick();

        // Reset state
        chk("rst.rx_rst", 32'(rx_rst), 32'(1));
        chk("rst.rx_en", 32'(rx_en), 32'(0));
        chk("rst.rx_baud", 32'(rx_baud), 32'(0));
        chk("rst.cfg_err", 32'(cfg_err), 32'(0));
        chk("rst.size", 32'(rx_char_size), 32'(8));
        check_fifo("rst");
        rst = 1'b0;
        tick();

        // rdy activity while OFF never pushes
        rx_rdy = 1'b0; repeat (3) tick(); rx_rdy = 1'b1; repeat (2) tick();
        check_fifo("off_nopush");

        // Enable; a rdy low/high during receiver reset is start-up noise
        cfg(1'b1, 1'b0, 16'd16, 4'd8);
        rx_rdy = 1'b0; repeat (2) tick(); rx_rdy = 1'b1; tick();
        chk("rxrst.rx_rst", 32'(rx_rst), 32'(1));
        wait_run();
        check_fifo("startup_nopush");
        baud_period(per);
        chk("baud_period16", 32'(per), 32'(16));

        send(8'hA5, 1'b0, 1'b0);
        check_fifo("a5");
        send(8'hFF, 1'b0, 1'b0);
        check_fifo("ff");

        // Shrink to 5 bits: restarts receiver for two baud periods, masks stale bits
        cfg(1'b1, 1'b0, 16'd16, 4'd5);
        wait_run();
        chk("rxrst_len_in_2_periods", 32'((rst_len >= 17) && (rst_len <= 32)), 32'(1));
        send(8'hEA, 1'b0, 1'b0);
        check_fifo("mask5");
        pop("pop_a5");
        pop("pop_ff");
        chk("masked_0a", 32'(rd_data), 32'(8'h0A));
        pop("pop_0a");
        pop("pop_empty");

        // Flush on a valid write
        send(8'h33, 1'b0, 1'b0);
        cfg(1'b1, 1'b1, 16'd16, 4'd8);
        check_fifo("flush");
        wait_run();

        // Nine characters into eight slots
        for (int i = 0; i < 9; i++) send(8'($urandom), 1'b0, 1'b0);
        check_fifo("ovf9");
        send(8'($urandom), 1'b0, 1'b1);
        check_fifo("ovf_set_wins");
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0; exp_ovf = 1'b0;
        check_fifo("ovf_clr");

        // Full with a coincident pop: no drop
        send(8'($urandom), 1'b1, 1'b0);
        check_fifo("full_push_pop");
        for (int i = 0; i < c_DEPTH; i++) pop("drain");

        // Empty with push and rd_en together: push only
        send(8'($urandom), 1'b1, 1'b0);
        check_fifo("empty_push_rd");

        // Rejected writes leave everything alone
        cfg(1'b0, 1'b1, 16'd40, 4'd4);
        check_fifo("bad4");
        chk("bad4.rx_en", 32'(rx_en), 32'(1));
        baud_period(per);
        chk("bad4.period", 32'(per), 32'(16));
        cfg(1'b0, 1'b1, 16'd40, 4'd9);
        check_fifo("bad9");
        chk("bad9.rx_rst", 32'(rx_rst), 32'(0));
        baud_period(per);
        chk("bad9.period", 32'(per), 32'(16));

        // Reset mid-character, then the partial frame's rdy must not land
        rx_rdy = 1'b0; repeat (3) tick();
        rst = 1'b1; repeat (2) tick(); rst = 1'b0;
        exp_q.delete(); exp_ovf = 1'b0; exp_size = 8;
        chk("midrst.rx_rst", 32'(rx_rst), 32'(1));
        chk("midrst.rx_en", 32'(rx_en), 32'(0));
        rx_rdy = 1'b1; repeat (2) tick();
        check_fifo("midrst_nopush");
        cfg(1'b1, 1'b0, 16'd16, 4'd8);
        wait_run();
        send(8'h3C, 1'b0, 1'b0);
        check_fifo("after_rst_3c");

        // Divisor below the minimum is clamped
        cfg(1'b1, 1'b0, 16'd1, 4'd8);
        wait_run();
        baud_period(per);
        chk("clamp_period2", 32'(per), 32'(2));

        // Disable
        cfg(1'b0, 1'b0, 16'd16, 4'd8);
        chk("off.rx_en", 32'(rx_en), 32'(0));
        chk("off.rx_rst", 32'(rx_rst), 32'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_uart_rx_ctrl
`default_nettype wire

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Controller that sequences one uart_receiver instance from the system clock domain. It generates the receiver's baud clock, owns rx_en, char_size and the receiver reset, and captures each completed character into a small show-ahead FIFO. It also flags overflow and exposes a config/pop interface to the CPU-side bus logic.

Parameters:
CLK_DIV, 868, default system clocks per baud period (100 MHz / 115200)
FIFO_DEPTH, 8, character FIFO entries; power of two, at least 2
DIV_W, 16, width of the baud divisor

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
cfg_wr  in  1  one-cycle config write strobe
cfg_en  in  1  receiver enable written on cfg_wr
cfg_flush  in  1  on cfg_wr, empty the FIFO
cfg_div  in  DIV_W  clocks per baud period
cfg_char_size  in  4  bits per character, 5..8
cfg_err  out  1  one-cycle pulse: cfg_wr rejected
rd_en  in  1  pop head of FIFO
rd_valid  out  1  FIFO not empty
rd_data  out  8  FIFO head (show-ahead)
fifo_count  out  $clog2(FIFO_DEPTH)+1  occupancy
overflow  out  1  sticky: a character was dropped
ovf_clr  in  1  clear overflow
rx_baud  out  1  baud clock to receiver
rx_rst  out  1  receiver reset
rx_en  out  1  receiver enable
rx_char_size  out  4  receiver character size
rx_rdy  in  1  receiver ready flag
rx_data  in  8  receiver data output

Behaviour:
- Reset values: state OFF, rx_rst=1, rx_en=0, rx_baud=0, baud counter 0, div=CLK_DIV, char_size=8, FIFO empty, rd_valid=0, fifo_count=0, overflow=0, cfg_err=0, rdy_q=1, armed=0.
- Baud generator: counter runs 0..div-1 in every state except reset. rx_baud is registered and equals (cnt < div>>1). Its rising edge (bwrap) follows cnt wrapping to 0. A cfg_div value below 2 is clamped to 2. A new div takes effect at the next wrap, with no glitch mid-period.
- Config: on cfg_wr with cfg_char_size outside 5..8, the whole write is ignored and cfg_err pulses the next cycle.
  - Otherwise div and char_size latch. If cfg_flush=1, the FIFO empties that cycle.
  - Next state is RXRST if cfg_en=1, else OFF.
  - rx_char_size always drives the latched char_size.
- FSM:
  - OFF: rx_rst=1, rx_en=0.
  - RXRST: rx_rst=1, rx_en=0. Hold for 2 bwrap events, because the receiver only samples rst on baud edges. Then go to RUN with armed=0.
  - RUN: rx_rst=0, rx_en=1. Stays in RUN until a valid cfg_wr.
- Capture: rdy_q is rx_rdy registered on clk. A low level of rx_rdy seen in RUN sets armed.
  - A push fires when state=RUN, armed=1, rx_rdy=1 and rdy_q=0. The push clears armed until rx_rdy goes low again.
  - A rising rdy edge without a prior low in RUN (start-up) never pushes.
- Data mask: the pushed value is rx_data with bits [7:char_size] forced to 0. This removes stale scratch bits left from a longer earlier character.
- FIFO: push at tail, rd_data = head. A pop occurs when rd_en=1 and rd_valid=1; rd_en while empty is ignored. Pointers wrap modulo FIFO_DEPTH.
  - Full + push, no pop: character dropped, overflow set, count unchanged.
  - Full + push + pop: both occur, no overflow, count stays FIFO_DEPTH.
  - Empty + push + rd_en: push only, count becomes 1.
- overflow: ovf_clr clears it. If ovf_clr and an overflow event occur in the same cycle, set wins.
- Reset mid-character: rst returns to OFF with rx_rst=1. A partial character is never pushed; armed=0 guarantees this.
- Latency: push occurs 1 clk after rx_rdy rises in the clk domain. rd_valid rises the cycle after the push.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding OFF/RXRST/RUN;
  - CHAR_MIN=5, CHAR_MAX=8, DIV_MIN=2;
  - default CLK_DIV.
- Sub-module uart_rx_fifo: synchronous show-ahead FIFO with push/pop/flush, count, full/empty. Overflow detection stays in the controller.

Test Plan:
- Reset, then cfg_wr(en=1, div=16, size=8); drive the receiver with 0xA5. Required: rx_rst high for 2 baud periods; rd_valid=1, rd_data=0xA5, fifo_count=1.
- size=8, receive 0xFF; then cfg size=5 and receive 0x0A. Required: second entry is 0x0A, upper bits masked.
- Receive 9 characters with FIFO_DEPTH=8 and no pops. Required: count=8, overflow=1, first 8 characters intact in order; ovf_clr then clears overflow.
- FIFO full and a push coincides with rd_en. Required: overflow stays 0, count stays 8, new character at tail.
- cfg_wr with size=4, then size=9. Required: cfg_err pulses each time, div/size unchanged, state unchanged.
- Assert rst mid-character, then re-enable. Required: no push from the partial frame; the next full frame 0x3C is captured correctly.
